// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter
// per entry, EX-side resolution/update, and branch/mispredict performance counters.
module branch_predictor #(
  parameter int ENTRY_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  output logic        PredictF,
  output logic [31:0] NPC_Pred,
  input  logic        BranchE,
  input  logic        BrTakenE,
  input  logic [31:0] PC_EX,
  input  logic [31:0] BrTargetE,
  input  logic        PredictE,
  output logic        MispredictE,
  output logic [31:0] NPC_Correct,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 32 - ENTRY_BITS - 2;

  typedef logic [ENTRY_BITS-1:0] idx_t;
  typedef logic [TAG_W-1:0]      tag_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  logic        valid_q  [ENTRIES];
  tag_t        tag_q    [ENTRIES];
  logic [31:0] target_q [ENTRIES];
  ctr_e        cnt_q    [ENTRIES];
  logic [31:0] branch_cnt_q, miss_cnt_q;

  idx_t idx_f, idx_e;
  tag_t tag_f, tag_e;
  logic hit_f, hit_e;
  logic cnt_we;
  ctr_e cnt_d;

  assign idx_f = PC_IF[ENTRY_BITS+1:2];
  assign tag_f = PC_IF[31:ENTRY_BITS+2];
  assign idx_e = PC_EX[ENTRY_BITS+1:2];
  assign tag_e = PC_EX[31:ENTRY_BITS+2];

  // Lookup reads registered state only, so a same-index update is visible next cycle.
  assign hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredictF = hit_f && cnt_q[idx_f][1];
  assign NPC_Pred = PredictF ? target_q[idx_f] : PC_IF + 32'd4;

  assign hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign MispredictE = BranchE && (PredictE != BrTakenE);
  assign NPC_Correct = BrTakenE ? BrTargetE : PC_EX + 32'd4;

  assign BranchCnt = branch_cnt_q;
  assign MissCnt   = miss_cnt_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q[idx_e];
    cnt_we = 1'b0;
    if (hit_e) begin
      cnt_we = 1'b1;
      if (BrTakenE) begin
        if (cnt_q[idx_e] != STRONG_T) cnt_d = ctr_e'(cnt_q[idx_e] + 2'd1);
      end else begin
        if (cnt_q[idx_e] != STRONG_NT) cnt_d = ctr_e'(cnt_q[idx_e] - 2'd1);
      end
    end else if (BrTakenE) begin
      cnt_we = 1'b1;
      cnt_d  = WEAK_T;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: only valid and cnt are reset; tag/target are don't-care while valid=0,
      // so they stay plain enable flops (reset just holds them).
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= WEAK_NT;
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (BranchE) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (MispredictE) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (cnt_we) cnt_q[idx_e] <= cnt_d;
      // A taken branch either refreshes its own entry or evicts whatever aliased there.
      if (BrTakenE) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= BrTargetE;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed lookups, resolutions,
// counter saturation, aliasing, same-cycle ordering and asynchronous reset.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF;
  logic        PredictF;
  logic [31:0] NPC_Pred;
  logic        BranchE, BrTakenE, PredictE;
  logic [31:0] PC_EX, BrTargetE;
  logic        MispredictE;
  logic [31:0] NPC_Correct, BranchCnt, MissCnt;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.ENTRY_BITS(6)) dut (
    .clk(clk), .rst(rst), .PC_IF(PC_IF), .PredictF(PredictF), .NPC_Pred(NPC_Pred),
    .BranchE(BranchE), .BrTakenE(BrTakenE), .PC_EX(PC_EX), .BrTargetE(BrTargetE),
    .PredictE(PredictE), .MispredictE(MispredictE), .NPC_Correct(NPC_Correct),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic exp_pred,
                        input logic [31:0] exp_npc);
    PC_IF = pc;
    #1;
    check({name, ".PredictF"}, 32'(PredictF), 32'(exp_pred));
    check({name, ".NPC_Pred"}, NPC_Pred, exp_npc);
  endtask

  // Present one EX branch for a single cycle, check the combinational resolution, then clock it in.
  task automatic resolve(input string name, input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic pred, input logic exp_mis,
                         input logic [31:0] exp_corr);
    BranchE = 1'b1; PC_EX = pc; BrTakenE = taken; BrTargetE = tgt; PredictE = pred;
    #1;
    check({name, ".MispredictE"}, 32'(MispredictE), 32'(exp_mis));
    if (exp_mis) check({name, ".NPC_Correct"}, NPC_Correct, exp_corr);
    @(posedge clk);
    #1;
    BranchE = 1'b0;
  endtask

  task automatic counters(input string name, input logic [31:0] exp_br, input logic [31:0] exp_miss);
    check({name, ".BranchCnt"}, BranchCnt, exp_br);
    check({name, ".MissCnt"}, MissCnt, exp_miss);
  endtask

  initial begin
    rst = 1'b1; PC_IF = 32'h100; BranchE = 1'b0; BrTakenE = 1'b0; PredictE = 1'b0;
    PC_EX = '0; BrTargetE = '0;
    #1;
    lookup("in_reset", 32'h100, 1'b0, 32'h104);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    lookup("after_reset", 32'h100, 1'b0, 32'h104);
    counters("after_reset", 32'd0, 32'd0);
    lookup("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Allocate 0x100 -> 0x200; lookup of the same index in that cycle sees the old table.
    lookup("same_cycle_old", 32'h100, 1'b0, 32'h104);
    resolve("alloc", 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
    lookup("same_cycle_new", 32'h100, 1'b1, 32'h200);
    counters("alloc", 32'd1, 32'd1);

    // 10 -> 01 -> 00; a taken then only reaches 01, proving the floor held.
    resolve("nt1", 32'h100, 1'b0, 32'h200, 1'b1, 1'b1, 32'h104);
    lookup("nt1", 32'h100, 1'b0, 32'h104);
    resolve("nt2", 32'h100, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0);
    lookup("nt2", 32'h100, 1'b0, 32'h104);
    resolve("t_from_00", 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
    lookup("t_from_00", 32'h100, 1'b0, 32'h104);
    counters("dec", 32'd4, 32'd3);

    // Fresh entry at 0x40: four takens saturate at 11; NT -> 10 (taken), NT -> 01.
    resolve("sat_t1", 32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
    resolve("sat_t2", 32'h40, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
    resolve("sat_t3", 32'h40, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
    resolve("sat_t4", 32'h40, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
    lookup("sat_11", 32'h40, 1'b1, 32'h80);
    resolve("sat_nt1", 32'h40, 1'b0, 32'h80, 1'b1, 1'b1, 32'h44);
    lookup("sat_10", 32'h40, 1'b1, 32'h80);
    resolve("sat_nt2", 32'h40, 1'b0, 32'h80, 1'b1, 1'b1, 32'h44);
    lookup("sat_01", 32'h40, 1'b0, 32'h44);
    counters("sat", 32'd10, 32'd6);

    // BranchE=0 must ignore every EX input.
    BranchE = 1'b0; PC_EX = 32'h40; BrTakenE = 1'b1; BrTargetE = 32'h999; PredictE = 1'b0;
    #1;
    check("idle.MispredictE", 32'(MispredictE), 32'd0);
    @(posedge clk);
    #1;
    lookup("idle", 32'h40, 1'b0, 32'h44);
    counters("idle", 32'd10, 32'd6);

    // Alias: 0x200 shares the index of 0x100 and evicts it.
    resolve("realloc", 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
    lookup("realloc", 32'h100, 1'b1, 32'h200);
    resolve("alias", 32'h200, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300);
    lookup("alias_old", 32'h100, 1'b0, 32'h104);
    lookup("alias_new", 32'h200, 1'b1, 32'h300);
    counters("alias", 32'd12, 32'd8);

    // Reset asserted with an update pending: clears at once and the edge writes nothing.
    PC_IF = 32'h200;
    BranchE = 1'b1; PC_EX = 32'h40; BrTakenE = 1'b1; BrTargetE = 32'h500; PredictE = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_async.PredictF", 32'(PredictF), 32'd0);
    check("rst_async.NPC_Pred", NPC_Pred, 32'h204);
    counters("rst_async", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    BranchE = 1'b0;
    rst = 1'b0;
    lookup("rst_nowrite", 32'h40, 1'b0, 32'h44);
    counters("rst_nowrite", 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
